// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter: sticky per-line pending events issued as a
// strictly one-hot grant word under a valid/ready handshake.
module onehot_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    input  logic         gnt_ready,
    output logic [N-1:0] pending
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          found;
    logic          slot_free;
    logic          accept;
    logic          load;
    logic [N-1:0]  sel_oh;
    logic [N-1:0]  clr;

    // First set bit of the registered pending word, scanning from ptr upward.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign slot_free = !gnt_valid || gnt_ready;
    assign accept    = gnt_valid && gnt_ready;
    assign load      = slot_free && found;
    assign sel_oh    = {{(N-1){1'b0}}, 1'b1} << sel;
    assign clr       = load ? sel_oh : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            // req is OR'd in after the clear so a same-edge re-request survives.
            pending <= (pending & ~clr) | req;
            if (load) begin
                gnt       <= sel_oh;
                gnt_valid <= 1'b1;
                ptr       <= sel + PW'(1);
            end else if (accept) begin
                gnt       <= '0;
                gnt_valid <= 1'b0;
            end
        end
    end

endmodule
